// File: rtl/divisor_m.sv
// Iterative restoring divider for the rv32i M-extension: DIV, DIVU, REM, REMU.
// One quotient bit per clock; divide-by-zero and signed overflow take a short path.
module divisor_m #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             init,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] DV_in,
   input  logic [WIDTH-1:0] DR_in,
   output logic             busy,
   output logic             ready,
   output logic [WIDTH-1:0] result
);

   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CALC    = 2'd1,
      S_FIX     = 2'd2,
      S_SPECIAL = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic             busy_q, busy_d;
   logic             ready_q, ready_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             init_prev_q, init_prev_d;
   logic             armed_q, armed_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] dr_q, dr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       op_q, op_d;
   logic             q_neg_q, q_neg_d;
   logic             r_neg_q, r_neg_d;

   logic             start;
   logic             dv_neg, dr_neg;
   logic [WIDTH-1:0] dv_mag, dr_mag;
   logic             dr_zero, ovf;
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH-1:0] rem_diff;
   logic             rem_ge;
   logic [WIDTH-1:0] fix_sel;
   logic             fix_neg;

   // Start is a rising edge of init, only once init has been seen low since reset
   assign start = init & ~init_prev_q & armed_q;

   // Operand sign handling and special-case detection at the start edge
   assign dv_neg  = ~op[0] & DV_in[WIDTH-1];
   assign dr_neg  = ~op[0] & DR_in[WIDTH-1];
   assign dv_mag  = dv_neg ? (~DV_in + WIDTH'(1)) : DV_in;
   assign dr_mag  = dr_neg ? (~DR_in + WIDTH'(1)) : DR_in;
   assign dr_zero = (DR_in == '0);
   assign ovf     = ~op[0] & (DV_in == MIN_NEG) & (DR_in == '1);

   // Restoring step; the partial remainder keeps its top bit so large unsigned divisors stay exact
   assign rem_shift = {a_q, q_q[WIDTH-1]};
   assign rem_ge    = (rem_shift >= {1'b0, dr_q});
   assign rem_diff  = rem_shift[WIDTH-1:0] - dr_q;

   // Final sign correction: quotient follows q_neg, remainder follows the dividend sign
   assign fix_sel = op_q[1] ? a_q : q_q;
   assign fix_neg = ~op_q[0] & (op_q[1] ? r_neg_q : q_neg_q);

   // Next-state and datapath update
   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      ready_d     = ready_q;
      result_d    = result_q;
      init_prev_d = init;
      armed_d     = armed_q | ~init;
      a_d         = a_q;
      q_d         = q_q;
      dr_d        = dr_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      q_neg_d     = q_neg_q;
      r_neg_d     = r_neg_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = op;
               busy_d  = 1'b1;
               ready_d = 1'b0;
               q_neg_d = dv_neg ^ dr_neg;
               r_neg_d = dv_neg;
               if (dr_zero) begin
                  a_d     = op[1] ? DV_in : '1;
                  state_d = S_SPECIAL;
               end else if (ovf) begin
                  a_d     = op[1] ? '0 : DV_in;
                  state_d = S_SPECIAL;
               end else begin
                  a_d     = '0;
                  q_d     = dv_mag;
                  dr_d    = dr_mag;
                  cnt_d   = CNT_INIT;
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (rem_ge) begin
               a_d = rem_diff;
               q_d = {q_q[WIDTH-2:0], 1'b1};
            end else begin
               a_d = rem_shift[WIDTH-1:0];
               q_d = {q_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNT_LAST;
            if (cnt_q == CNT_LAST) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            result_d = fix_neg ? (~fix_sel + WIDTH'(1)) : fix_sel;
            ready_d  = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
         end
         S_SPECIAL: begin
            result_d = a_q;
            ready_d  = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         ready_q     <= 1'b0;
         result_q    <= '0;
         init_prev_q <= 1'b0;
         armed_q     <= 1'b0;
         a_q         <= '0;
         q_q         <= '0;
         dr_q        <= '0;
         cnt_q       <= '0;
         op_q        <= '0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         ready_q     <= ready_d;
         result_q    <= result_d;
         init_prev_q <= init_prev_d;
         armed_q     <= armed_d;
         a_q         <= a_d;
         q_q         <= q_d;
         dr_q        <= dr_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         q_neg_q     <= q_neg_d;
         r_neg_q     <= r_neg_d;
      end
   end

   assign busy   = busy_q;
   assign ready  = ready_q;
   assign result = result_q;

endmodule

// File: tb/tb_divisor_m.sv
// Directed bench for divisor_m (WIDTH=32) plus a short random sweep against a reference model.
module tb_divisor_m;

   logic        clk;
   logic        rst_n;
   logic        init;
   logic [1:0]  op;
   logic [31:0] dv;
   logic [31:0] dr;
   logic        busy;
   logic        ready;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   divisor_m #(.WIDTH(32), .CNT_W(6)) dut (
      .clk    (clk),
      .reset  (rst_n),
      .init   (init),
      .op     (op),
      .DV_in  (dv),
      .DR_in  (dr),
      .busy   (busy),
      .ready  (ready),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Raise init just after edge k, count edges until ready, then drop init
   task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bcnt);
      bit done;
      op   = o;
      dv   = a;
      dr   = b;
      init = 1'b1;
      lat  = 0;
      bcnt = 0;
      done = 1'b0;
      for (int i = 1; i <= 100 && !done; i++) begin
         tick();
         if (busy) bcnt++;
         if (ready) begin
            lat  = i;
            done = 1'b1;
         end
      end
      init = 1'b0;
      tick();
   endtask

   function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
      if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : a;
      case (o)
         2'b00: return 32'($signed(a) / $signed(b));
         2'b01: return a / b;
         2'b10: return 32'($signed(a) % $signed(b));
         default: return a % b;
      endcase
   endfunction

   int lat, bcnt, rises;
   logic rdy_prev;
   logic [31:0] ra, rb;
   logic [1:0]  ro;

   initial begin
      rst_n = 1'b0;
      init  = 1'b0;
      op    = 2'b00;
      dv    = '0;
      dr    = '0;
      #12;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_ready", 32'(ready), 32'd0);
      chk("reset_result", result, 32'd0);
      rst_n = 1'b1;
      tick();
      tick();

      // 1. unsigned basic with latency
      do_op(2'b01, 32'd100, 32'd7, lat, bcnt);
      chk("divu_100_7", result, 32'd14);
      chk("divu_latency", 32'(lat), 32'd34);
      chk("divu_busy_cycles", 32'(bcnt), 32'd33);
      tick(); tick();
      chk("result_hold_idle", result, 32'd14);
      chk("ready_hold_idle", 32'(ready), 32'd1);
      do_op(2'b11, 32'd100, 32'd7, lat, bcnt);
      chk("remu_100_7", result, 32'd2);

      // 2. signed
      do_op(2'b00, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
      chk("div_m7_2", result, 32'hFFFF_FFFD);
      do_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
      chk("rem_m7_2", result, 32'hFFFF_FFFF);
      do_op(2'b10, 32'd7, 32'hFFFF_FFFE, lat, bcnt);
      chk("rem_7_m2", result, 32'd1);
      do_op(2'b00, 32'd7, 32'hFFFF_FFFE, lat, bcnt);
      chk("div_7_m2", result, 32'hFFFF_FFFD);
      do_op(2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFF9, lat, bcnt);
      chk("div_m100_m7", result, 32'd14);
      do_op(2'b10, 32'hFFFF_FF9C, 32'hFFFF_FFF9, lat, bcnt);
      chk("rem_m100_m7", result, 32'hFFFF_FFFE);
      do_op(2'b00, 32'h8000_0000, 32'd2, lat, bcnt);
      chk("div_min_2", result, 32'hC000_0000);

      // large unsigned divisor
      do_op(2'b01, 32'hFFFF_FFFF, 32'h8000_0001, lat, bcnt);
      chk("divu_big", result, 32'd1);
      do_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, lat, bcnt);
      chk("remu_big", result, 32'h7FFF_FFFE);
      do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
      chk("divu_min_allones", result, 32'd0);

      // 3. divide by zero
      do_op(2'b01, 32'd5, 32'd0, lat, bcnt);
      chk("divu_5_0", result, 32'hFFFF_FFFF);
      chk("divu0_latency", 32'(lat), 32'd2);
      chk("divu0_busy_cycles", 32'(bcnt), 32'd1);
      do_op(2'b10, 32'd5, 32'd0, lat, bcnt);
      chk("rem_5_0", result, 32'd5);
      chk("rem0_latency", 32'(lat), 32'd2);
      do_op(2'b00, 32'd5, 32'd0, lat, bcnt);
      chk("div_5_0", result, 32'hFFFF_FFFF);

      // 4. signed overflow
      do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
      chk("div_ovf", result, 32'h8000_0000);
      chk("div_ovf_latency", 32'(lat), 32'd2);
      do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
      chk("rem_ovf", result, 32'd0);
      chk("rem_ovf_latency", 32'(lat), 32'd2);

      // 5. second init rise while busy is ignored
      op = 2'b01; dv = 32'd100; dr = 32'd7; init = 1'b1;
      rises = 0; rdy_prev = ready;
      for (int i = 1; i <= 80; i++) begin
         tick();
         if (i == 3) init = 1'b0;
         if (i == 5) begin
            op = 2'b11; dv = 32'd50; dr = 32'd3; init = 1'b1;
         end
         if (ready && !rdy_prev) rises++;
         rdy_prev = ready;
      end
      chk("busy_ignore_rises", 32'(rises), 32'd1);
      chk("busy_ignore_result", result, 32'd14);
      chk("busy_ignore_ready", 32'(ready), 32'd1);
      init = 1'b0;
      tick();

      // 6. reset mid-operation with init held high
      op = 2'b01; dv = 32'd100; dr = 32'd7; init = 1'b1;
      for (int i = 1; i <= 10; i++) tick();
      rst_n = 1'b0;
      #1;
      chk("midreset_busy", 32'(busy), 32'd0);
      chk("midreset_ready", 32'(ready), 32'd0);
      chk("midreset_result", result, 32'd0);
      tick();
      rst_n = 1'b1;
      rises = 0;
      for (int i = 1; i <= 50; i++) begin
         tick();
         if (ready || busy) rises++;
      end
      chk("no_start_init_high", 32'(rises), 32'd0);
      init = 1'b0;
      tick();
      do_op(2'b01, 32'd100, 32'd7, lat, bcnt);
      chk("after_reset_divu", result, 32'd14);
      chk("after_reset_latency", 32'(lat), 32'd34);

      // random sweep
      for (int n = 0; n < 24; n++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom();
         rb = (n % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom();
         if (n % 4 == 1) rb = 32'($signed(-32'sd1) * 32'sd0 - 32'sd13);
         do_op(ro, ra, rb, lat, bcnt);
         chk("random", result, ref_div(ro, ra, rb));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
